// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32 load/store unit.
// Holds funct3 encodings, the FSM state enum and the default memory depth.
package lsu_pkg;

    localparam int LSU_MEM_WORDS = 1000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD_WAIT,
        S_WR,
        S_RMW_WAIT,
        S_RMW_WR,
        S_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract + sign/zero extend, store merge.
// Ports: funct3/off select the lane, rword is the memory word, wdata the
// store data; ldata is the extended load value, mword the merged word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mword
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rword[{off, 3'b000} +: 8];
        lane_h = rword[{off[1], 4'b0000} +: 16];

        ldata = rword;
        unique case (funct3)
            F3_B:    ldata = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ldata = {24'h0, lane_b};
            F3_H:    ldata = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ldata = {16'h0, lane_h};
            default: ldata = rword;
        endcase

        // Only the target lane is replaced; other bytes pass through.
        mword = rword;
        case (funct3)
            F3_B:    mword[{off, 3'b000} +: 8] = wdata[7:0];
            F3_H:    mword[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: mword = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit in front of a word-addressed data memory.
// Ports: req_* request handshake, resp_* one-cycle response pulse,
// d_r_en/d_w_en/d_add/data_in/d_out memory side.
// Optional: define LSU_BOUNDS_CHECK_EN to flag word addresses >= MEM_WORDS.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        d_r_en,
    output logic        d_w_en,
    output logic [31:0] d_add,
    output logic [31:0] data_in,
    input  logic [31:0] d_out
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        f3_ok;
    logic        req_err;
    logic [31:0] ldata;
    logic [31:0] mword;

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: f3_ok = 1'b1;
            F3_H, F3_HU: f3_ok = !req_addr[0];
            F3_W:        f3_ok = (req_addr[1:0] == 2'b00);
            default:     f3_ok = 1'b0;
        endcase
        // Stores only exist as B/H/W; the unsigned encodings are loads only.
        req_err = !f3_ok
                || (req_we && req_funct3[2])
                || (BOUNDS_EN && (req_addr[31:2] >= MEM_LIMIT));
    end

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        d_r_en     = 1'b0;
        d_w_en     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = !rst;
                if (accept) begin
                    if (req_err)
                        state_d = S_RESP;
                    else if (req_we && req_funct3 == F3_W)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                d_r_en  = !rst;
                state_d = we_q ? S_RMW_WAIT : S_LD_WAIT;
            end
            S_LD_WAIT:  state_d = S_RESP;
            S_RMW_WAIT: state_d = S_RMW_WR;
            S_WR, S_RMW_WR: begin
                d_w_en  = !rst;
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = !rst;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    lsu_align u_align (
        .funct3 (f3_q),
        .off    (addr_q[1:0]),
        .rword  (d_out),
        .wdata  (data_q),
        .ldata  (ldata),
        .mword  (mword)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                // Store data parks here until the merge overwrites it.
                data_q  <= req_wdata;
                rdata_q <= 32'h0;
                err_q   <= req_err;
            end
            if (state_q == S_LD_WAIT)
                rdata_q <= ldata;
            if (state_q == S_RMW_WAIT)
                data_q <= mword;
        end
    end

    assign d_add      = {2'b00, addr_q[31:2]};
    assign data_in    = data_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: reference model + memory model.
// Directed test-plan cases, a mid-RMW reset, then random traffic.
module tb_load_store_unit;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wa;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        d_r_en;
    logic        d_w_en;
    logic [31:0] d_add;
    logic [31:0] data_in;
    logic [31:0] d_out = 32'h0;

    load_store_unit #(.MEM_WORDS(1000)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .d_r_en     (d_r_en),
        .d_w_en     (d_w_en),
        .d_add      (d_add),
        .data_in    (data_in),
        .d_out      (d_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (d_w_en) mem[d_add[9:0]] <= data_in;
        if (d_r_en) d_out <= mem[d_add[9:0]];
    end

    exp_t q[$];
    int nvec = 0;
    int nfail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(bit we, bit [2:0] f3, bit [31:0] addr,
                                   bit [31:0] wd);
        exp_t e;
        bit ill;
        int unsigned wi;
        int unsigned sh;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        wi = addr / 4;
        sh = 8 * (addr % 4);
        case (f3)
            3'd0, 3'd4: ill = 1'b0;
            3'd1, 3'd5: ill = (addr % 2) != 0;
            3'd2:       ill = (addr % 4) != 0;
            default:    ill = 1'b1;
        endcase
        if (we && f3 > 3'd2) ill = 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
        if (wi >= 1000) ill = 1'b1;
`endif
        e.wa = wi;
        e.rdata = 32'h0;
        word = ref_mem[wi % 1024];
        if (ill) begin
            e.err = 1'b1; e.lat = 1; e.rd = 0; e.wr = 0;
        end else if (!we) begin
            e.err = 1'b0; e.lat = 3; e.rd = 1; e.wr = 0;
            case (f3)
                3'd0: begin
                    v = (word >> sh) & 32'hFF;
                    e.rdata = (v >= 128) ? v + 32'hFFFFFF00 : v;
                end
                3'd4: e.rdata = (word >> sh) & 32'hFF;
                3'd1: begin
                    v = (word >> sh) & 32'hFFFF;
                    e.rdata = (v >= 32768) ? v + 32'hFFFF0000 : v;
                end
                3'd5: e.rdata = (word >> sh) & 32'hFFFF;
                default: e.rdata = word;
            endcase
        end else begin
            e.err = 1'b0; e.wr = 1;
            if (f3 == 3'd2) begin
                e.lat = 2; e.rd = 0;
                ref_mem[wi % 1024] = wd;
            end else begin
                e.lat = 4; e.rd = 1;
                mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
                ref_mem[wi % 1024] = (word & ~(mask << sh)) | ((wd & mask) << sh);
            end
        end
        return e;
    endfunction

    int acc_cyc = 0;
    int rdc = 0;
    int wrc = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (d_r_en || d_w_en) begin
                chk("rw_exclusive", {31'h0, d_r_en & d_w_en}, 32'h0);
                if (q.size() > 0) chk("d_add", d_add, q[0].wa);
                rdc += int'(d_r_en);
                wrc += int'(d_w_en);
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                rdc = 0;
                wrc = 0;
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_resp: got resp_valid expected none");
                end else begin
                    e = q.pop_front();
                    chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("latency", cyc - acc_cyc, e.lat);
                    chk("rd_count", rdc, e.rd);
                    chk("wr_count", wrc, e.wr);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(bit we, bit [2:0] f3, bit [31:0] addr, bit [31:0] wd);
        int budget;
        q.push_back(model(we, f3, addr, wd));
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        budget = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            budget++;
            if (budget > 50) begin
                $display("FAIL req_ready_timeout: got 0 expected 1");
                nfail++;
                $fatal(1, "request never accepted");
            end
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_wdata  = $urandom;
        req_addr   = $urandom;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() > 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        #1;
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic rnd_req();
        bit we;
        bit [2:0] f3;
        bit [31:0] wi;
        we = 1'($urandom % 2);
        if ($urandom % 100 < 85) begin
            case ($urandom % 5)
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
        end else begin
            f3 = 3'($urandom);
        end
        if ($urandom % 10 == 0) wi = 996 + ($urandom % 8);
        else wi = $urandom % 16;
        issue(we, f3, (wi << 2) | ($urandom % 4), $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[3] = 32'h8899AABB;
        ref_mem[3] = 32'h8899AABB;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {27'h0, req_ready, resp_valid, d_r_en, d_w_en, resp_err},
            32'h0);
        chk("rst_d_add", d_add, 32'h0);
        chk("rst_data_in", data_in, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;

        issue(1'b0, 3'd0, 32'h0D, 32'h0);
        issue(1'b0, 3'd4, 32'h0D, 32'h0);
        issue(1'b1, 3'd0, 32'h0E, 32'h11);
        issue(1'b0, 3'd2, 32'h0C, 32'h0);
        issue(1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
        issue(1'b0, 3'd2, 32'h20, 32'h0);
        issue(1'b0, 3'd1, 32'h03, 32'h0);
        issue(1'b0, 3'd2, 32'h02, 32'h0);
        issue(1'b0, 3'd3, 32'h10, 32'h0);
        issue(1'b0, 3'd2, 32'd3996, 32'h0);
        issue(1'b0, 3'd2, 32'd4000, 32'h0);
        drain();

        // SH abandoned by reset while the merge is pending.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd1;
        req_addr   = 32'h26;
        req_wdata  = 32'h0000CAFE;
        @(negedge clk);
        chk("sh_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_en", {30'h0, d_r_en, d_w_en}, 32'h0);
        chk("rst_mid_resp", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_rst", {31'h0, req_ready}, 32'h1);
        chk("word9_unchanged", mem[9], ref_mem[9]);
        @(posedge clk);
        #1;
        issue(1'b0, 3'd2, 32'h24, 32'h0);
        drain();

        for (int n = 0; n < 300; n++) begin
            rnd_req();
            repeat ($urandom % 3) @(posedge clk);
            #1;
        end
        drain();
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
